dac_push: RTL

DAC_PUSH -- requirements
Module: dac_push

---
 rtl/dac_push.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dac_push.sv
// ---------------------------------------------------------------------------
// dac_push -- pushes one 16-bit command frame {channel, 2'b11, data_in} to a
// serial DAC over an SPI mode-0 link (SCLK idles low, MOSI MSB first).
//
// Parameters
//   HALF_PERIOD : clk cycles per dac_sclk half-period (1..255).
//
// Ports
//   clk      in   single clock, everything on posedge
//   reset    in   synchronous, active-high
//   data_in  in   12-bit DAC sample code
//   channel  in   2-bit DAC channel select
//   valid    in   request to send data_in/channel
//   ready    out  idle and able to accept a request
//   dac_cs_n out  active-low chip select
//   dac_sclk out  serial clock
//   dac_mosi out  serial data, MSB first
//   done     out  one-cycle pulse when the frame has been shifted out
//
// Frame timing: SETUP (1 half-period) + 16 x (high + low half-periods) keeps
// cs_n low for 33*HALF_PERIOD cycles, followed by a GAP half-period with cs_n
// high, then one IDLE cycle with ready=1 before the next frame can start.
// ---------------------------------------------------------------------------
module dac_push #(
    parameter int HALF_PERIOD = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] data_in,
    input  logic [1:0]  channel,
    input  logic        valid,
    output logic        ready,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_mosi,
    output logic        done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_SHIFT_HI = 3'd2;
    localparam logic [2:0] S_SHIFT_LO = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;

    localparam logic [7:0] HP_RELOAD = 8'(HALF_PERIOD - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  hcnt_q,  hcnt_d;
    logic [3:0]  bit_q,   bit_d;
    logic [15:0] shift_q, shift_d;
    logic        ready_q, ready_d;
    logic        cs_n_q,  cs_n_d;
    logic        sclk_q,  sclk_d;
    logic        done_q,  done_d;
    logic        hp_end;

    assign hp_end = (hcnt_q == 8'd0);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        case (state_q)
            S_IDLE: begin
                // ready_q is only ever 1 in IDLE, so it doubles as the handshake qualifier
                if (ready_q && valid) begin
                    state_d = S_SETUP;
                    shift_d = {channel, 2'b11, data_in};
                    bit_d   = 4'd0;
                end
            end
            S_SETUP: begin
                if (hp_end) state_d = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
                if (hp_end) begin
                    state_d = S_SHIFT_LO;
                    bit_d   = 4'(bit_q + 4'd1);
                    // Advance MOSI on the falling edge, except after bit 0,
                    // which is held through the final low phase.
                    if (bit_q != 4'd15) shift_d = {shift_q[14:0], 1'b0};
                end
            end
            S_SHIFT_LO: begin
                if (hp_end) begin
                    // bit_q wrapped to 0 after the 16th high phase
                    if (bit_q == 4'd0) begin
                        state_d = S_GAP;
                        shift_d = '0;
                    end else begin
                        state_d = S_SHIFT_HI;
                    end
                end
            end
            S_GAP: begin
                if (hp_end) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                shift_d = '0;
            end
        endcase

        // Half-period counter: reload on every state change, otherwise count
        // down and stick at zero.
        if (state_d != state_q) begin
            hcnt_d = HP_RELOAD;
        end else if (!hp_end) begin
            hcnt_d = hcnt_q - 8'd1;
        end else begin
            hcnt_d = hcnt_q;
        end

        // Outputs are registered copies of what the next state implies.
        ready_d = (state_d == S_IDLE);
        cs_n_d  = !((state_d == S_SETUP) || (state_d == S_SHIFT_HI) ||
                    (state_d == S_SHIFT_LO));
        sclk_d  = (state_d == S_SHIFT_HI);
        done_d  = (state_d == S_GAP) && (state_q != S_GAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ready_q <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
        end
    end

    assign ready    = ready_q;
    assign dac_cs_n = cs_n_q;
    assign dac_sclk = sclk_q;
    // The shift register is cleared on GAP entry and reset, so its MSB is
    // already the registered MOSI value in every state.
    assign dac_mosi = shift_q[15];
    assign done     = done_q;

endmodule
